// File: rtl/hazard_ctrl_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module  : hazard_ctrl_pipe_pkg
// Purpose : Shared constants for the pipeline control/hazard block: the
//           "no register" index, EX operand source encodings and the default
//           bit positions of the load and RF-enable flags in the control word.
// Ports   : (package - none)
// Rev     : 1.0  initial release
// ============================================================================
package hazard_ctrl_pipe_pkg;

  // Register index that never names a real destination or source.
  localparam int REG_ZERO = 0;

  // EX operand source select encodings.
  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  // Default flag positions inside the control word.
  localparam int DEF_LOAD_BIT = 10;
  localparam int DEF_RFEN_BIT = 9;

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_pipe_fwd_select.sv
`default_nettype none
// ============================================================================
// Module  : fwd_select
// Purpose : Chooses the source of one EX operand. A younger writer (EX/MEM)
//           takes priority over an older one (MEM/WB); register 0 never
//           forwards.
// Ports   : src_i      - register index read by the EX instruction
//           mem_rfen_i - EX/MEM stage writes the register file
//           mem_dest_i - EX/MEM stage destination
//           wb_rfen_i  - MEM/WB stage writes the register file
//           wb_dest_i  - MEM/WB stage destination
//           sel_o      - FWD_RF / FWD_EXMEM / FWD_MEMWB
// Rev     : 1.0  initial release
// ============================================================================
module fwd_select
  import hazard_ctrl_pipe_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src_i,
  input  logic              mem_rfen_i,
  input  logic [REG_AW-1:0] mem_dest_i,
  input  logic              wb_rfen_i,
  input  logic [REG_AW-1:0] wb_dest_i,
  output logic [1:0]        sel_o
);

  localparam logic [REG_AW-1:0] C_ZERO = REG_AW'(REG_ZERO);

  always_comb begin
    sel_o = FWD_RF;
    if (mem_rfen_i && (mem_dest_i != C_ZERO) && (mem_dest_i == src_i)) begin
      sel_o = FWD_EXMEM;
    end else if (wb_rfen_i && (wb_dest_i != C_ZERO) && (wb_dest_i == src_i)) begin
      sel_o = FWD_MEMWB;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl_pipe.sv
`default_nettype none
// ============================================================================
// Module  : hazard_ctrl_pipe
// Purpose : IF/ID instruction register plus ID/EX, EX/MEM and MEM/WB control
//           and destination registers. Detects load-use hazards (stall and
//           bubble), produces EX forwarding selects, annuls IF/ID on flush
//           (deferring the annul when it coincides with a stall) and counts
//           stall cycles with saturation.
// Ports   : clk, reset (async, active-high)
//           if_instr          - fetched instruction
//           id_instr          - IF/ID contents, to the control unit
//           id_ctrl/id_dest   - decode of id_instr
//           id_uses_rs/_rt    - ID instruction reads rs / rt
//           ctrl_nop          - force a bubble into ID/EX
//           flush             - annul IF/ID
//           ex_/mem_/wb_ctrl  - stage control words
//           ex_/mem_/wb_dest  - stage destination registers
//           stall             - load-use stall, holds PC/nPC
//           fwd_a, fwd_b      - EX operand sources for rs / rt
//           stall_cnt         - saturating stall cycle count
// Rev     : 1.0  initial release
// ============================================================================
module hazard_ctrl_pipe
  import hazard_ctrl_pipe_pkg::*;
#(
  parameter int INSTR_W  = 32,
  parameter int CTRL_W   = 17,
  parameter int REG_AW   = 5,
  parameter int LOAD_BIT = DEF_LOAD_BIT,
  parameter int RFEN_BIT = DEF_RFEN_BIT,
  parameter int CNT_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] if_instr,
  output logic [INSTR_W-1:0] id_instr,
  input  logic [CTRL_W-1:0]  id_ctrl,
  input  logic [REG_AW-1:0]  id_dest,
  input  logic               id_uses_rs,
  input  logic               id_uses_rt,
  input  logic               ctrl_nop,
  input  logic               flush,
  output logic [CTRL_W-1:0]  ex_ctrl,
  output logic [CTRL_W-1:0]  mem_ctrl,
  output logic [CTRL_W-1:0]  wb_ctrl,
  output logic [REG_AW-1:0]  ex_dest,
  output logic [REG_AW-1:0]  mem_dest,
  output logic [REG_AW-1:0]  wb_dest,
  output logic               stall,
  output logic [1:0]         fwd_a,
  output logic [1:0]         fwd_b,
  output logic [CNT_W-1:0]   stall_cnt
);

  localparam logic [REG_AW-1:0] C_ZERO    = REG_AW'(REG_ZERO);
  localparam logic [CNT_W-1:0]  C_CNT_MAX = {CNT_W{1'b1}};

  logic [INSTR_W-1:0] id_instr_q, id_instr_d;
  logic [CTRL_W-1:0]  ex_ctrl_q, ex_ctrl_d, mem_ctrl_q, wb_ctrl_q;
  logic [REG_AW-1:0]  ex_dest_q, ex_dest_d, mem_dest_q, wb_dest_q;
  logic [REG_AW-1:0]  ex_rs_q, ex_rs_d, ex_rt_q, ex_rt_d;
  logic               flush_pend_q, flush_pend_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  logic [REG_AW-1:0]  w_id_rs, w_id_rt;
  logic               w_load_use;

  assign w_id_rs = REG_AW'(id_instr_q[25:21]);
  assign w_id_rt = REG_AW'(id_instr_q[20:16]);

  // The load in EX has no data until MEM, so a dependent ID instruction
  // must wait one cycle.
  assign w_load_use = ex_ctrl_q[LOAD_BIT] && (ex_dest_q != C_ZERO) &&
                      ((id_uses_rs && (ex_dest_q == w_id_rs)) ||
                       (id_uses_rt && (ex_dest_q == w_id_rt)));

  always_comb begin
    // IF/ID: a flush seen during a stall is remembered and applied on the
    // first edge that is allowed to update the register.
    id_instr_d   = id_instr_q;
    flush_pend_d = 1'b0;
    if (w_load_use) begin
      flush_pend_d = flush_pend_q | flush;
    end else if (flush || flush_pend_q) begin
      id_instr_d = '0;
    end else begin
      id_instr_d = if_instr;
    end

    // ID/EX: bubble on stall or on request.
    ex_ctrl_d = '0;
    ex_dest_d = '0;
    ex_rs_d   = '0;
    ex_rt_d   = '0;
    if (!(w_load_use || ctrl_nop)) begin
      ex_ctrl_d = id_ctrl;
      ex_dest_d = id_dest;
      ex_rs_d   = w_id_rs;
      ex_rt_d   = w_id_rt;
    end

    stall_cnt_d = stall_cnt_q;
    if (w_load_use && (stall_cnt_q != C_CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_instr_q   <= '0;
      ex_ctrl_q    <= '0;
      ex_dest_q    <= '0;
      ex_rs_q      <= '0;
      ex_rt_q      <= '0;
      mem_ctrl_q   <= '0;
      mem_dest_q   <= '0;
      wb_ctrl_q    <= '0;
      wb_dest_q    <= '0;
      flush_pend_q <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      id_instr_q   <= id_instr_d;
      ex_ctrl_q    <= ex_ctrl_d;
      ex_dest_q    <= ex_dest_d;
      ex_rs_q      <= ex_rs_d;
      ex_rt_q      <= ex_rt_d;
      mem_ctrl_q   <= ex_ctrl_q;
      mem_dest_q   <= ex_dest_q;
      wb_ctrl_q    <= mem_ctrl_q;
      wb_dest_q    <= mem_dest_q;
      flush_pend_q <= flush_pend_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  fwd_select #(.REG_AW(REG_AW)) u_fwd_a (
    .src_i      (ex_rs_q),
    .mem_rfen_i (mem_ctrl_q[RFEN_BIT]),
    .mem_dest_i (mem_dest_q),
    .wb_rfen_i  (wb_ctrl_q[RFEN_BIT]),
    .wb_dest_i  (wb_dest_q),
    .sel_o      (fwd_a)
  );

  fwd_select #(.REG_AW(REG_AW)) u_fwd_b (
    .src_i      (ex_rt_q),
    .mem_rfen_i (mem_ctrl_q[RFEN_BIT]),
    .mem_dest_i (mem_dest_q),
    .wb_rfen_i  (wb_ctrl_q[RFEN_BIT]),
    .wb_dest_i  (wb_dest_q),
    .sel_o      (fwd_b)
  );

  assign id_instr  = id_instr_q;
  assign ex_ctrl   = ex_ctrl_q;
  assign mem_ctrl  = mem_ctrl_q;
  assign wb_ctrl   = wb_ctrl_q;
  assign ex_dest   = ex_dest_q;
  assign mem_dest  = mem_dest_q;
  assign wb_dest   = wb_dest_q;
  assign stall     = w_load_use;
  assign stall_cnt = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_hazard_ctrl_pipe
// Purpose : Scoreboard bench for hazard_ctrl_pipe. A stimulus process drives
//           directed and random cycles and pushes the reference model's
//           expected outputs; a monitor process pops and compares. A second
//           instance with a 2-bit stall counter shares the inputs.
// Rev     : 1.0  initial release
// ============================================================================
module tb_hazard_ctrl_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] if_instr = '0;
  logic [16:0] id_ctrl = '0;
  logic [4:0]  id_dest = '0;
  logic        id_uses_rs = 1'b0, id_uses_rt = 1'b0, ctrl_nop = 1'b0, flush = 1'b0;

  logic [31:0] id_instr, id_instr2;
  logic [16:0] ex_ctrl, mem_ctrl, wb_ctrl, ex_ctrl2, mem_ctrl2, wb_ctrl2;
  logic [4:0]  ex_dest, mem_dest, wb_dest, ex_dest2, mem_dest2, wb_dest2;
  logic        stall, stall2;
  logic [1:0]  fwd_a, fwd_b, fwd_a2, fwd_b2;
  logic [15:0] stall_cnt;
  logic [1:0]  stall_cnt2;

  hazard_ctrl_pipe dut (
    .clk(clk), .reset(reset), .if_instr(if_instr), .id_instr(id_instr),
    .id_ctrl(id_ctrl), .id_dest(id_dest), .id_uses_rs(id_uses_rs),
    .id_uses_rt(id_uses_rt), .ctrl_nop(ctrl_nop), .flush(flush),
    .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl),
    .ex_dest(ex_dest), .mem_dest(mem_dest), .wb_dest(wb_dest),
    .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt)
  );

  hazard_ctrl_pipe #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .if_instr(if_instr), .id_instr(id_instr2),
    .id_ctrl(id_ctrl), .id_dest(id_dest), .id_uses_rs(id_uses_rs),
    .id_uses_rt(id_uses_rt), .ctrl_nop(ctrl_nop), .flush(flush),
    .ex_ctrl(ex_ctrl2), .mem_ctrl(mem_ctrl2), .wb_ctrl(wb_ctrl2),
    .ex_dest(ex_dest2), .mem_dest(mem_dest2), .wb_dest(wb_dest2),
    .stall(stall2), .fwd_a(fwd_a2), .fwd_b(fwd_b2), .stall_cnt(stall_cnt2)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [16:0] ctrl;
    logic [4:0]  dest;
    logic [4:0]  rs;
    logic [4:0]  rt;
  } stage_t;

  typedef struct packed {
    logic [31:0] id_instr;
    stage_t      ex, mem, wb;
    logic        stall;
    logic [1:0]  fa, fb;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
  } exp_t;

  localparam logic [16:0] LD = 17'h00400;   // load flag
  localparam logic [16:0] RF = 17'h00200;   // register-file write flag

  exp_t   exp_q[$];
  stage_t pipe[$];      // [0]=EX, [1]=MEM, [2]=WB
  logic [31:0] m_id;
  logic        m_fp;
  int          m_cnt;
  bit          m_last_stall;

  int checks = 0;
  int failures = 0;
  bit done = 1'b0;

  function automatic logic [1:0] fwd_of(input logic [4:0] src);
    // Youngest writer of src wins; register 0 is never forwarded.
    if (src == 5'd0) return 2'b00;
    for (int k = 1; k <= 2; k++)
      if (pipe[k].ctrl[9] && pipe[k].dest == src) return (k == 1) ? 2'b01 : 2'b10;
    return 2'b00;
  endfunction

  task automatic model_clear();
    stage_t z;
    z = '0;
    pipe = {z, z, z};
    m_id = '0;
    m_fp = 1'b0;
    m_cnt = 0;
  endtask

  task automatic step(input logic rst_v, input logic [31:0] ins,
                      input logic [16:0] ctl, input logic [4:0] dst,
                      input logic urs, input logic urt,
                      input logic nop, input logic fl);
    exp_t   e;
    stage_t nx;
    logic   st;
    @(negedge clk);
    reset = rst_v; if_instr = ins; id_ctrl = ctl; id_dest = dst;
    id_uses_rs = urs; id_uses_rt = urt; ctrl_nop = nop; flush = fl;
    if (rst_v) model_clear();
    st = !rst_v && pipe[0].ctrl[10] && pipe[0].dest != 0 &&
         ((urs && pipe[0].dest == m_id[25:21]) || (urt && pipe[0].dest == m_id[20:16]));
    e.id_instr = m_id;
    e.ex = pipe[0]; e.mem = pipe[1]; e.wb = pipe[2];
    e.stall = st;
    e.fa = fwd_of(pipe[0].rs);
    e.fb = fwd_of(pipe[0].rt);
    e.cnt  = (m_cnt > 65535) ? 16'hFFFF : 16'(m_cnt);
    e.cnt2 = (m_cnt > 3) ? 2'd3 : 2'(m_cnt);
    exp_q.push_back(e);
    m_last_stall = st;
    if (!rst_v) begin
      nx = (st || nop) ? stage_t'('0) : {ctl, dst, m_id[25:21], m_id[20:16]};
      pipe = {nx, pipe[0], pipe[1]};
      if (st) begin
        m_cnt++;
        m_fp = m_fp | fl;
      end else begin
        m_id = (fl || m_fp) ? 32'd0 : ins;
        m_fp = 1'b0;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: outputs are valid every cycle, sampled mid-low-phase.
  initial begin : monitor
    exp_t e;
    while (1) begin
      @(negedge clk);
      #3;
      if (done) break;
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL scoreboard_empty at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        chk("id_instr",  id_instr,          e.id_instr);
        chk("ex_ctrl",   32'(ex_ctrl),      32'(e.ex.ctrl));
        chk("mem_ctrl",  32'(mem_ctrl),     32'(e.mem.ctrl));
        chk("wb_ctrl",   32'(wb_ctrl),      32'(e.wb.ctrl));
        chk("ex_dest",   32'(ex_dest),      32'(e.ex.dest));
        chk("mem_dest",  32'(mem_dest),     32'(e.mem.dest));
        chk("wb_dest",   32'(wb_dest),      32'(e.wb.dest));
        chk("stall",     32'(stall),        32'(e.stall));
        chk("fwd_a",     32'(fwd_a),        32'(e.fa));
        chk("fwd_b",     32'(fwd_b),        32'(e.fb));
        chk("stall_cnt", 32'(stall_cnt),    32'(e.cnt));
        chk("stall_cnt_sat2", 32'(stall_cnt2), 32'(e.cnt2));
      end
    end
  end

  initial begin : stimulus
    logic [31:0] ins;
    logic [16:0] ctl;
    bit did_rst;
    did_rst = 1'b0;
    model_clear();
    // Reset, then ADDIU r9 / SUBU r10,r9,r9 / ADDU r10,r9,r9 forwarding chain.
    step(1, 32'h0, 17'h0, 5'd0, 0, 0, 0, 0);
    step(1, 32'h0, 17'h0, 5'd0, 0, 0, 0, 0);
    step(0, 32'h2409000A, 17'h0, 5'd0, 0, 0, 0, 0);
    step(0, 32'h01295023, RF, 5'd9, 1, 0, 0, 0);
    step(0, 32'h01295021, RF, 5'd10, 1, 1, 0, 0);
    step(0, 32'h8C080000, RF, 5'd10, 1, 1, 0, 0);
    // Load r8 then dependent ADDU with a coincident flush.
    step(0, 32'h01084021, LD | RF, 5'd8, 1, 0, 0, 0);
    step(0, 32'h00000000, RF, 5'd8, 1, 0, 0, 1);
    step(0, 32'h00000000, RF, 5'd8, 1, 0, 0, 0);
    step(0, 32'h00000000, 17'h0, 5'd0, 0, 0, 0, 0);
    // Load to r0 followed by a reader of r0: no stall, no forward.
    step(0, 32'h8C000000, 17'h0, 5'd0, 0, 0, 0, 0);
    step(0, 32'h00001021, LD | RF, 5'd0, 1, 1, 0, 0);
    step(0, 32'h00000000, RF, 5'd2, 1, 1, 0, 0);
    // Forced bubble while IF/ID keeps advancing.
    step(0, 32'h12345678, RF, 5'd3, 0, 0, 1, 0);
    step(0, 32'h0, 17'h0, 5'd0, 0, 0, 0, 0);
    step(0, 32'h0, 17'h0, 5'd0, 0, 0, 0, 0);
    step(0, 32'h0, 17'h0, 5'd0, 0, 0, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      ins = $urandom;
      ins[25:21] = 5'($urandom_range(0, 3));
      ins[20:16] = 5'($urandom_range(0, 3));
      ctl = 17'($urandom);
      ctl[10] = ($urandom_range(0, 9) < 4);
      ctl[9]  = ($urandom_range(0, 9) < 6);
      if (!did_rst && i > 1000 && m_last_stall) begin
        // Reset lands right after a stall cycle, dropping any pending flush.
        did_rst = 1'b1;
        step(1, ins, ctl, 5'($urandom_range(0, 3)), 1, 1, 0, 1);
      end else begin
        step(0, ins, ctl, 5'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 9) == 0), ($urandom_range(0, 6) == 0));
      end
    end

    @(negedge clk);
    done = 1'b1;
    #5;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl_pipe.md
Name: hazard_ctrl_pipe

Overview:
Parametrised successor to the fixed IF/ID, ID/EX, EX/MEM and MEM/WB control registers. It holds the fetched instruction and carries the control word plus destination register through EX, MEM and WB. It also detects load-use hazards (stall plus bubble), produces EX-stage forwarding selects, handles IF/ID annul (flush) with a pending mechanism, and counts stall cycles. It sits between the instruction memory/control unit and the datapath; its stall output holds PC/nPC.

Parameters:
INSTR_W, 32, instruction width
CTRL_W, 17, control word width
REG_AW, 5, register index width
LOAD_BIT, 10, index of the load-instruction bit in the control word
RFEN_BIT, 9, index of the RF-enable bit in the control word
CNT_W, 16, width of the stall counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
if_instr  in  INSTR_W  instruction from instruction memory
id_instr  out  INSTR_W  IF/ID register contents; feeds the control unit
id_ctrl  in  CTRL_W  control word decoded from id_instr
id_dest  in  REG_AW  destination register of the ID instruction (0 = none)
id_uses_rs  in  1  ID instruction reads rs (id_instr[25:21])
id_uses_rt  in  1  ID instruction reads rt (id_instr[20:16])
ctrl_nop  in  1  force a bubble into ID/EX; IF/ID still advances
flush  in  1  annul IF/ID on this edge
ex_ctrl, mem_ctrl, wb_ctrl  out  CTRL_W  stage control words
ex_dest, mem_dest, wb_dest  out  REG_AW  stage destination registers
stall  out  1  load-use stall; hold PC/nPC this cycle
fwd_a, fwd_b  out  2  EX operand source: 00 = RF, 01 = EX/MEM, 10 = MEM/WB
stall_cnt  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset (async): all registers go to 0. This includes id_instr, every stage ctrl/dest, the carried ex_rs/ex_rt, flush_pend and stall_cnt. Consequently stall=0 and fwd_a=fwd_b=00.
- Bubble definition: ctrl=0, dest=0, rs=0, rt=0.
- Load-use hazard (combinational) is asserted when all of these hold:
  - ex_ctrl[LOAD_BIT]=1,
  - ex_dest≠0,
  - (id_uses_rs and ex_dest==id_instr[25:21]) or (id_uses_rt and ex_dest==id_instr[20:16]).
- stall equals the load-use hazard signal.
- Per rising edge, in priority order:
  - IF/ID:
    - if stall, hold;
    - else if flush or flush_pend, load 0;
    - else load if_instr.
  - flush_pend:
    - set when flush=1 and stall=1;
    - cleared on the first non-stall edge, where it is consumed.
  - ID/EX:
    - if stall or ctrl_nop, load bubble;
    - else load id_ctrl, id_dest, id_instr[25:21], id_instr[20:16].
  - EX/MEM and MEM/WB: always advance, never stalled.
- Latency: ID to EX, MEM and WB in 1, 2 and 3 cycles respectively; IF/ID has 1-cycle latency.
- Forwarding (combinational, from registered state), fwd_a for ex_rs:
  - 01 if mem_ctrl[RFEN_BIT] and mem_dest≠0 and mem_dest==ex_rs;
  - else 10 if wb_ctrl[RFEN_BIT] and wb_dest≠0 and wb_dest==ex_rs;
  - else 00.
  - EX/MEM wins over MEM/WB when both match.
  - fwd_b is identical, using ex_rt.
- Register 0 never triggers a stall or a forward.
- stall_cnt:
  - +1 on each edge where stall=1;
  - saturates at all-ones, no wrap;
  - cleared only by reset.
- Reset asserted mid-stall: all state clears immediately; flush_pend is lost.

Decomposition:
- Shared package: REG_ZERO, FWD_RF=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10, and the default LOAD_BIT/RFEN_BIT positions.
- One sub-module: fwd_select, a combinational comparator instantiated twice (rs and rt).

Test Plan:
1. Reset release, then feed if_instr=0x2409000A (ADDIU r9) → id_instr=0x2409000A one cycle later; ex_ctrl=id_ctrl one cycle after that; outputs are 0 during reset.
2. ADDIU r9 (RF_EN=1, dest 9) followed by SUBU r10,r9,r9 → when SUBU is in EX, fwd_a=fwd_b=01; one cycle later, if the next instruction reads r9, fwd=10.
3. Load to r8 (LOAD=1, dest 8) followed by an instruction with rs=8, id_uses_rs=1 → stall=1 for exactly 1 cycle, id_instr held, ex_ctrl=0 next cycle, stall_cnt=1; then fwd_a=10 when the instruction reaches EX.
4. Load with dest 0, followed by an instruction with rs=0 → stall=0 and fwd=00 throughout.
5. flush=1 in the same cycle as stall=1 → IF/ID held that edge, then loaded 0 on the next edge; flush_pend=0 afterwards.
6. ctrl_nop=1 for 1 cycle → ex_ctrl=0 next cycle while id_instr still advances. Separately, with CNT_W=2, four stall cycles → stall_cnt=3 (saturated).
